// File: rtl/change_dispenser.sv
// Coin payout stage: pays a change balance greedily (quarter, dime, nickel), one coin per
// ejector handshake, while tracking a per-type inventory that can be restocked when idle.
module change_dispenser #(
    parameter int unsigned BAL_W      = 16,
    parameter int unsigned COUNT_W    = 8,
    parameter int unsigned MAX_COINS  = 200,
    parameter int unsigned INIT_COUNT = 20
) (
    input  logic               clk,
    input  logic               hrst_n,
    input  logic               srst,
    input  logic               balance_valid,
    input  logic [BAL_W-1:0]   balance,
    output logic               coin_valid,
    output logic [1:0]         coin_out,
    input  logic               coin_ready,
    output logic               busy,
    output logic               done,
    output logic               change_error,
    output logic [BAL_W-1:0]   remaining,
    input  logic               restock_valid,
    input  logic [1:0]         restock_coin,
    input  logic [COUNT_W-1:0] restock_count,
    output logic [COUNT_W-1:0] nickel_cnt,
    output logic [COUNT_W-1:0] dime_cnt,
    output logic [COUNT_W-1:0] quarter_cnt
);

    localparam logic [1:0] CoinNone    = 2'd0;
    localparam logic [1:0] CoinNickel  = 2'd1;
    localparam logic [1:0] CoinDime    = 2'd2;
    localparam logic [1:0] CoinQuarter = 2'd3;

    localparam logic [BAL_W-1:0]   ValNickel  = BAL_W'(5);
    localparam logic [BAL_W-1:0]   ValDime    = BAL_W'(10);
    localparam logic [BAL_W-1:0]   ValQuarter = BAL_W'(25);
    localparam logic [COUNT_W-1:0] CountInit  = COUNT_W'(INIT_COUNT);
    localparam logic [COUNT_W-1:0] CountMax   = COUNT_W'(MAX_COINS);

    typedef enum logic [2:0] {StIdle, StSelect, StEmit, StDone, StError} state_t;

    state_t state;

    logic [1:0]         pick;
    logic [COUNT_W-1:0] restock_base;
    logic [COUNT_W:0]   restock_sum;
    logic [COUNT_W-1:0] restock_new;

    function automatic logic [BAL_W-1:0] coin_value(input logic [1:0] c);
        case (c)
            CoinNickel:  return ValNickel;
            CoinDime:    return ValDime;
            CoinQuarter: return ValQuarter;
            default:     return '0;
        endcase
    endfunction

    // Largest affordable coin still in stock; NONE means change cannot be completed.
    always_comb begin
        pick = CoinNone;
        if (remaining >= ValQuarter && quarter_cnt != '0) begin
            pick = CoinQuarter;
        end else if (remaining >= ValDime && dime_cnt != '0) begin
            pick = CoinDime;
        end else if (remaining >= ValNickel && nickel_cnt != '0) begin
            pick = CoinNickel;
        end
    end

    always_comb begin
        restock_base = '0;
        case (restock_coin)
            CoinNickel:  restock_base = nickel_cnt;
            CoinDime:    restock_base = dime_cnt;
            CoinQuarter: restock_base = quarter_cnt;
            default:     restock_base = '0;
        endcase
        // One extra bit so a large restock saturates instead of wrapping.
        restock_sum = {1'b0, restock_base} + {1'b0, restock_count};
        restock_new = (restock_sum > (COUNT_W+1)'(MAX_COINS)) ? CountMax
                                                              : restock_sum[COUNT_W-1:0];
    end

    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            state        <= StIdle;
            coin_valid   <= 1'b0;
            coin_out     <= CoinNone;
            busy         <= 1'b0;
            done         <= 1'b0;
            change_error <= 1'b0;
            remaining    <= '0;
            nickel_cnt   <= CountInit;
            dime_cnt     <= CountInit;
            quarter_cnt  <= CountInit;
        end else if (srst) begin
            state        <= StIdle;
            coin_valid   <= 1'b0;
            coin_out     <= CoinNone;
            busy         <= 1'b0;
            done         <= 1'b0;
            change_error <= 1'b0;
            remaining    <= '0;
        end else begin
            done         <= 1'b0;
            change_error <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (balance_valid) begin
                        remaining <= balance;
                        busy      <= 1'b1;
                        if ((balance % ValNickel) != '0) begin
                            state        <= StError;
                            change_error <= 1'b1;
                        end else begin
                            state <= StSelect;
                        end
                    end else if (restock_valid) begin
                        case (restock_coin)
                            CoinNickel:  nickel_cnt  <= restock_new;
                            CoinDime:    dime_cnt    <= restock_new;
                            CoinQuarter: quarter_cnt <= restock_new;
                            default:     ;
                        endcase
                    end
                end
                StSelect: begin
                    if (remaining == '0) begin
                        state <= StDone;
                        done  <= 1'b1;
                    end else if (pick != CoinNone) begin
                        state      <= StEmit;
                        coin_out   <= pick;
                        coin_valid <= 1'b1;
                    end else begin
                        state        <= StError;
                        change_error <= 1'b1;
                    end
                end
                StEmit: begin
                    if (coin_ready) begin
                        remaining  <= remaining - coin_value(coin_out);
                        coin_valid <= 1'b0;
                        coin_out   <= CoinNone;
                        state      <= StSelect;
                        case (coin_out)
                            CoinNickel:  nickel_cnt  <= nickel_cnt - COUNT_W'(1);
                            CoinDime:    dime_cnt    <= dime_cnt - COUNT_W'(1);
                            CoinQuarter: quarter_cnt <= quarter_cnt - COUNT_W'(1);
                            default:     ;
                        endcase
                    end
                end
                StDone: begin
                    state     <= StIdle;
                    busy      <= 1'b0;
                    remaining <= '0;
                end
                StError: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy payout, stalls, errors, restock and resets.
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        hrst_n;
    logic        srst;
    logic        balance_valid;
    logic [15:0] balance;
    logic        coin_ready;
    logic        restock_valid;
    logic [1:0]  restock_coin;
    logic [7:0]  restock_count;

    logic        coin_valid, busy, done, change_error;
    logic [1:0]  coin_out;
    logic [15:0] remaining;
    logic [7:0]  nickel_cnt, dime_cnt, quarter_cnt;

    // Second instance with a single coin of each type, for the inventory-exhaustion case.
    logic        b_coin_valid, b_busy, b_done, b_change_error;
    logic [1:0]  b_coin_out;
    logic [15:0] b_remaining;
    logic [7:0]  b_nickel_cnt, b_dime_cnt, b_quarter_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    change_dispenser #(.BAL_W(16), .COUNT_W(8), .MAX_COINS(200), .INIT_COUNT(20)) dut (
        .clk(clk), .hrst_n(hrst_n), .srst(srst),
        .balance_valid(balance_valid), .balance(balance),
        .coin_valid(coin_valid), .coin_out(coin_out), .coin_ready(coin_ready),
        .busy(busy), .done(done), .change_error(change_error), .remaining(remaining),
        .restock_valid(restock_valid), .restock_coin(restock_coin),
        .restock_count(restock_count),
        .nickel_cnt(nickel_cnt), .dime_cnt(dime_cnt), .quarter_cnt(quarter_cnt)
    );

    change_dispenser #(.BAL_W(16), .COUNT_W(8), .MAX_COINS(200), .INIT_COUNT(1)) dut_one (
        .clk(clk), .hrst_n(hrst_n), .srst(srst),
        .balance_valid(balance_valid), .balance(balance),
        .coin_valid(b_coin_valid), .coin_out(b_coin_out), .coin_ready(coin_ready),
        .busy(b_busy), .done(b_done), .change_error(b_change_error),
        .remaining(b_remaining),
        .restock_valid(restock_valid), .restock_coin(restock_coin),
        .restock_count(restock_count),
        .nickel_cnt(b_nickel_cnt), .dime_cnt(b_dime_cnt), .quarter_cnt(b_quarter_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] bal);
        balance       = bal;
        balance_valid = 1'b1;
        tick;
        balance_valid = 1'b0;
    endtask

    task automatic test_reset;
        hrst_n = 1'b0;
        tick;
        tick;
        total++;
        if ({coin_valid, coin_out, busy, done, change_error, remaining} !== 22'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b/%0d/%b/%b/%b/%0d want all zero",
                     coin_valid, coin_out, busy, done, change_error, remaining);
        end
        total++;
        if ({nickel_cnt, dime_cnt, quarter_cnt} !== {8'd20, 8'd20, 8'd20}) begin
            bad++;
            $display("FAIL reset_counts: got %0d/%0d/%0d want 20/20/20",
                     nickel_cnt, dime_cnt, quarter_cnt);
        end
        hrst_n = 1'b1;
        tick;
    endtask

    task automatic test_greedy;
        logic [1:0] exp_coin [7] = '{2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0};
        coin_ready = 1'b1;
        start(16'd40);
        total++;
        if ({busy, coin_valid} !== 2'b10) begin
            bad++;
            $display("FAIL greedy_cycle1: got busy=%b valid=%b want 1/0", busy, coin_valid);
        end
        for (int i = 0; i < 7; i++) begin
            tick;
            total++;
            if ({coin_valid, coin_out, done} !== {exp_coin[i] != 2'd0, exp_coin[i], i == 6}) begin
                bad++;
                $display("FAIL greedy_cycle%0d: got valid=%b coin=%0d done=%b want %b/%0d/%b",
                         i + 2, coin_valid, coin_out, done,
                         exp_coin[i] != 2'd0, exp_coin[i], i == 6);
            end
        end
        total++;
        if ({nickel_cnt, dime_cnt, quarter_cnt, remaining} !== {8'd19, 8'd19, 8'd19, 16'd0}) begin
            bad++;
            $display("FAIL greedy_counts: got %0d/%0d/%0d rem=%0d want 19/19/19 rem=0",
                     nickel_cnt, dime_cnt, quarter_cnt, remaining);
        end
        tick;
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL greedy_idle: got busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_odd_and_zero;
        logic seen_valid = 1'b0;
        coin_ready = 1'b1;
        start(16'd7);
        total++;
        if ({change_error, coin_valid, remaining} !== {1'b1, 1'b0, 16'd7}) begin
            bad++;
            $display("FAIL odd_error: got err=%b valid=%b rem=%0d want 1/0/7",
                     change_error, coin_valid, remaining);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            seen_valid |= coin_valid;
        end
        total++;
        if ({seen_valid, change_error, busy, remaining} !== {3'b000, 16'd7}) begin
            bad++;
            $display("FAIL odd_after: got valid_seen=%b err=%b busy=%b rem=%0d want 0/0/0/7",
                     seen_valid, change_error, busy, remaining);
        end
        start(16'd0);
        tick;
        total++;
        if ({done, coin_valid, remaining} !== {1'b1, 1'b0, 16'd0}) begin
            bad++;
            $display("FAIL zero_done: got done=%b valid=%b rem=%0d want 1/0/0",
                     done, coin_valid, remaining);
        end
        tick;
    endtask

    task automatic test_stall;
        coin_ready = 1'b0;
        start(16'd25);
        tick;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({coin_valid, coin_out, quarter_cnt} !== {1'b1, 2'd3, 8'd19}) begin
                bad++;
                $display("FAIL stall_hold%0d: got valid=%b coin=%0d q=%0d want 1/3/19",
                         i, coin_valid, coin_out, quarter_cnt);
            end
            tick;
        end
        coin_ready = 1'b1;
        tick;
        total++;
        if ({coin_valid, coin_out, quarter_cnt, remaining} !== {1'b0, 2'd0, 8'd18, 16'd0}) begin
            bad++;
            $display("FAIL stall_accept: got valid=%b coin=%0d q=%0d rem=%0d want 0/0/18/0",
                     coin_valid, coin_out, quarter_cnt, remaining);
        end
        tick;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL stall_done: got done=%b want 1", done);
        end
        tick;
    endtask

    task automatic test_restock;
        restock_valid = 1'b1;
        restock_coin  = 2'd3;
        restock_count = 8'd250;
        tick;
        restock_coin  = 2'd1;
        restock_count = 8'd5;
        tick;
        restock_coin  = 2'd0;
        restock_count = 8'd50;
        tick;
        restock_valid = 1'b0;
        total++;
        if ({nickel_cnt, dime_cnt, quarter_cnt} !== {8'd24, 8'd19, 8'd200}) begin
            bad++;
            $display("FAIL restock_idle: got %0d/%0d/%0d want 24/19/200",
                     nickel_cnt, dime_cnt, quarter_cnt);
        end
        // Restock presented while a dime is waiting on the ejector.
        coin_ready = 1'b0;
        start(16'd10);
        tick;
        restock_valid = 1'b1;
        restock_coin  = 2'd2;
        restock_count = 8'd5;
        tick;
        restock_valid = 1'b0;
        total++;
        if ({coin_valid, coin_out, dime_cnt} !== {1'b1, 2'd2, 8'd19}) begin
            bad++;
            $display("FAIL restock_busy: got valid=%b coin=%0d d=%0d want 1/2/19",
                     coin_valid, coin_out, dime_cnt);
        end
        coin_ready = 1'b1;
        tick;
        tick;
        tick;
        total++;
        if ({busy, dime_cnt} !== {1'b0, 8'd18}) begin
            bad++;
            $display("FAIL restock_busy_end: got busy=%b d=%0d want 0/18", busy, dime_cnt);
        end
        // Balance and restock in the same cycle: the restock is lost.
        restock_valid = 1'b1;
        restock_coin  = 2'd1;
        restock_count = 8'd10;
        start(16'd5);
        restock_valid = 1'b0;
        total++;
        if ({busy, nickel_cnt} !== {1'b1, 8'd24}) begin
            bad++;
            $display("FAIL restock_collide: got busy=%b n=%0d want 1/24", busy, nickel_cnt);
        end
        for (int i = 0; i < 4; i++) tick;
        total++;
        if ({busy, nickel_cnt} !== {1'b0, 8'd23}) begin
            bad++;
            $display("FAIL restock_collide_end: got busy=%b n=%0d want 0/23", busy, nickel_cnt);
        end
    endtask

    task automatic test_resets_mid_emit;
        coin_ready = 1'b0;
        start(16'd25);
        tick;
        #2;
        hrst_n = 1'b0;
        #1;
        total++;
        if ({coin_valid, busy, nickel_cnt, dime_cnt, quarter_cnt} !==
            {2'b00, 8'd20, 8'd20, 8'd20}) begin
            bad++;
            $display("FAIL async_reset: got valid=%b busy=%b %0d/%0d/%0d want 0/0 20/20/20",
                     coin_valid, busy, nickel_cnt, dime_cnt, quarter_cnt);
        end
        tick;
        hrst_n = 1'b1;
        tick;
        start(16'd25);
        tick;
        coin_ready = 1'b1;
        srst       = 1'b1;
        tick;
        srst = 1'b0;
        total++;
        if ({coin_valid, coin_out, busy, done, change_error, remaining, quarter_cnt} !==
            {6'b000000, 16'd0, 8'd20}) begin
            bad++;
            $display("FAIL srst_emit: got v=%b c=%0d b=%b d=%b e=%b rem=%0d q=%0d want 0s q=20",
                     coin_valid, coin_out, busy, done, change_error, remaining, quarter_cnt);
        end
        tick;
        total++;
        if ({busy, done, change_error, quarter_cnt} !== {3'b000, 8'd20}) begin
            bad++;
            $display("FAIL srst_after: got b=%b d=%b e=%b q=%0d want 0/0/0/20",
                     busy, done, change_error, quarter_cnt);
        end
    endtask

    task automatic test_exhaust;
        logic [1:0] exp_coin [6] = '{2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
        hrst_n = 1'b0;
        tick;
        hrst_n     = 1'b1;
        coin_ready = 1'b1;
        tick;
        start(16'd45);
        for (int i = 0; i < 6; i++) begin
            tick;
            total++;
            if ({b_coin_valid, b_coin_out, b_change_error} !==
                {exp_coin[i] != 2'd0, exp_coin[i], 1'b0}) begin
                bad++;
                $display("FAIL exhaust_cycle%0d: got valid=%b coin=%0d err=%b want %b/%0d/0",
                         i + 2, b_coin_valid, b_coin_out, b_change_error,
                         exp_coin[i] != 2'd0, exp_coin[i]);
            end
        end
        tick;
        total++;
        if ({b_change_error, b_done, b_remaining, b_nickel_cnt, b_dime_cnt, b_quarter_cnt} !==
            {2'b10, 16'd5, 8'd0, 8'd0, 8'd0}) begin
            bad++;
            $display("FAIL exhaust_error: got err=%b done=%b rem=%0d %0d/%0d/%0d want 1/0/5 0/0/0",
                     b_change_error, b_done, b_remaining,
                     b_nickel_cnt, b_dime_cnt, b_quarter_cnt);
        end
        tick;
        total++;
        if ({b_change_error, b_busy, b_remaining} !== {2'b00, 16'd5}) begin
            bad++;
            $display("FAIL exhaust_idle: got err=%b busy=%b rem=%0d want 0/0/5",
                     b_change_error, b_busy, b_remaining);
        end
    endtask

    initial begin
        hrst_n        = 1'b0;
        srst          = 1'b0;
        balance_valid = 1'b0;
        balance       = '0;
        coin_ready    = 1'b0;
        restock_valid = 1'b0;
        restock_coin  = '0;
        restock_count = '0;
        test_reset;
        test_greedy;
        test_odd_and_zero;
        test_stall;
        test_restock;
        test_resets_mid_emit;
        test_exhaust;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of the vending-machine FSM. It consumes the computed change balance (cents) and pays it out as physical coins, one coin per handshake with the coin-ejector mechanism.
- Tracks its own nickel/dime/quarter inventory, which the supplier restocks while the block is idle.
- Pays greedily, largest coin first. It reports done, or error when exact change cannot be made.

Parameters:
- BAL_W, 16, width of balance and remaining (cents)
- COUNT_W, 8, width of each coin inventory counter
- MAX_COINS, 200, saturation limit per coin tube
- INIT_COUNT, 20, inventory value per coin type after reset

Ports:
- clk  in  1  clock, rising edge
- hrst_n  in  1  asynchronous active-low reset
- srst  in  1  synchronous abort to IDLE; inventory is kept
- balance_valid  in  1  one-cycle pulse: balance is valid
- balance  in  BAL_W  change to pay, in cents
- coin_valid  out  1  coin_out is presented to the ejector
- coin_out  out  2  0=NONE, 1=NICKEL(5), 2=DIME(10), 3=QUARTER(25)
- coin_ready  in  1  ejector accepts coin_out this cycle
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse: full change paid
- change_error  out  1  one-cycle pulse: change cannot be completed
- remaining  out  BAL_W  cents still owed
- restock_valid  in  1  restock request
- restock_coin  in  2  coin type to restock (same encoding as coin_out)
- restock_count  in  COUNT_W  number of coins added
- nickel_cnt, dime_cnt, quarter_cnt  out  COUNT_W each  current inventory

Behaviour:
- Reset (hrst_n low, asynchronous):
  - state=IDLE; coin_valid=0, coin_out=NONE, busy=0, done=0, change_error=0, remaining=0.
  - All three coin counts = INIT_COUNT.
- States: IDLE, SELECT, EMIT, DONE, ERROR.
- IDLE:
  - On balance_valid, latch remaining=balance.
  - If balance mod 5 != 0, go to ERROR; no coins are paid.
  - Otherwise go to SELECT. busy rises the cycle after balance_valid.
- SELECT (one cycle):
  - If remaining==0, go to DONE.
  - Otherwise pick the largest coin c with value(c) <= remaining and count(c) > 0. Priority is QUARTER, then DIME, then NICKEL.
  - A coin was found: register coin_out=c, go to EMIT.
  - No coin qualifies: go to ERROR.
- EMIT:
  - coin_valid=1; coin_out is held stable until coin_ready.
  - On coin_valid&&coin_ready: remaining -= value(c), count(c) -= 1, coin_valid drops, coin_out=NONE, go to SELECT.
  - Maximum throughput is one coin per 2 cycles.
- Latency: balance_valid in cycle 0 gives coin_valid in cycle 2.
- DONE: done=1 for one cycle, remaining=0, then IDLE.
- ERROR: change_error=1 for one cycle, then IDLE. remaining keeps the unpaid amount until the next accepted balance_valid. Coins already paid are not refunded.
- balance_valid while busy: ignored.
- coin_ready while coin_valid=0: ignored.
- Restock:
  - Accepted only in IDLE with no balance_valid that same cycle. balance_valid has priority; the simultaneous restock is dropped.
  - count = min(count + restock_count, MAX_COINS); the sum is computed COUNT_W+1 bits wide, with no wrap-around.
  - restock_coin=NONE is ignored. Restock while busy is ignored.
- srst (synchronous, any state): go to IDLE next edge; coin_valid=0, coin_out=NONE, remaining=0, no done/error pulse. Counts are unchanged, including no decrement for a coin presented that cycle. srst has priority over all other inputs.
- Counts never underflow: SELECT never picks a coin whose count is 0.

Test Plan:
- Inventory 20/20/20, balance=40, coin_ready held high → coin_out QUARTER, DIME, NICKEL on cycles 2, 4, 6; done pulse on cycle 8; counts 19/19/19; remaining=0.
- INIT_COUNT=1, balance=45 → QUARTER, DIME, NICKEL paid, then change_error pulse with remaining=5; counts 0/0/0.
- balance=7 → change_error at cycle 1, coin_valid never asserted, remaining=7. Then balance=0 → done pulse with no coins.
- balance=25, coin_ready low 5 cycles then high → coin_valid=1 and coin_out=QUARTER stable all 5 cycles; quarter_cnt decrements only on the ready cycle.
- In IDLE, restock QUARTER count=250 → quarter_cnt=200. Restock DIME during EMIT → dime_cnt unchanged. Restock in the same cycle as balance_valid → restock dropped.
- hrst_n low mid-EMIT → coin_valid=0 immediately (asynchronous); counts=INIT_COUNT. srst mid-EMIT with coin_ready=1 → IDLE next edge, no decrement, no pulses.
